// File: rtl/muxn_scan.sv
// muxn_scan: registered N-to-1 multiplexer with a one-shot channel sequencer.
//
// MODE=0 makes it a plain registered mux steered by SELECT. MODE=1 with a
// START pulse sweeps channels 0..N-1 once, showing each for DWELL+1 cycles
// and flagging the last sample of the sweep with DONE.
//
// Output handshake: VALID high means DATA_OUT/CHANNEL carry a sample in this
// cycle. There is no ready; a consumer that does not take the sample in that
// cycle loses it.
//
// STATE exposes the sequencer state (0 = idle, 1 = scanning) for checkers.
module muxn_scan #(
    parameter int N       = 8,
    parameter int W       = 1,
    parameter int DWELL_W = 8,
    localparam int SEL_W  = $clog2(N)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic [N*W-1:0]     DATA_IN,
    input  logic [SEL_W-1:0]   SELECT,
    input  logic               MODE,
    input  logic               START,
    input  logic [DWELL_W-1:0] DWELL,
    output logic [W-1:0]       DATA_OUT,
    output logic [SEL_W-1:0]   CHANNEL,
    output logic               VALID,
    output logic               DONE,
    output logic               STATE
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N - 1);

    logic [0:0]         state;
    logic [0:0]         state_next;
    logic [SEL_W-1:0]   ch;
    logic [SEL_W-1:0]   ch_next;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_next;
    logic [DWELL_W-1:0] dw;
    logic [DWELL_W-1:0] dw_next;
    logic               done_next;

    logic [W-1:0]       slice [N];
    logic               scanning;
    logic               load;
    logic [SEL_W-1:0]   pick;

    // Unpack the flat input bus into one W-bit slice per channel.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            slice[i] = DATA_IN[i*W +: W];
        end
    end

    // Choose which channel gets registered this edge. Dropping MODE during a
    // sweep falls through to the manual path so the abort edge already shows
    // SELECT data.
    always_comb begin
        scanning = (state == ST_SCAN) && MODE;
        load     = !MODE || scanning;
        pick     = scanning ? ch : SELECT;
    end

    // Sequencer next-state and counter logic. The dwell value is latched at
    // start so DWELL may change freely while a sweep runs.
    always_comb begin
        state_next = state;
        ch_next    = ch;
        cnt_next   = cnt;
        dw_next    = dw;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MODE && START) begin
                    state_next = ST_SCAN;
                    ch_next    = '0;
                    cnt_next   = DWELL;
                    dw_next    = DWELL;
                end
            end
            ST_SCAN: begin
                if (!MODE) begin
                    state_next = ST_IDLE;
                end else if (cnt != '0) begin
                    cnt_next = cnt - 1'b1;
                end else if (ch != LAST_CH) begin
                    ch_next  = ch + 1'b1;
                    cnt_next = dw;
                end else begin
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
            ch    <= '0;
            cnt   <= '0;
            dw    <= '0;
        end else begin
            state <= state_next;
            ch    <= ch_next;
            cnt   <= cnt_next;
            dw    <= dw_next;
        end
    end

    // Registered outputs; DATA_OUT and CHANNEL hold whenever nothing is loaded.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            DATA_OUT <= '0;
            CHANNEL  <= '0;
            VALID    <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            if (load) begin
                DATA_OUT <= slice[pick];
                CHANNEL  <= pick;
                VALID    <= 1'b1;
            end else begin
                VALID    <= 1'b0;
            end
            DONE <= done_next;
        end
    end

    assign STATE = state[0];

endmodule

// File: tb/tb_muxn_scan.sv
// tb_muxn_scan: self-checking bench for muxn_scan, with one N=8/W=1 instance
// and one N=4/W=4 instance. Expected sweeps come from a simple model of the
// sweep order (channel index = sample number / (dwell+1)).
module tb_muxn_scan;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: N=8, W=1 ----------------
    logic [7:0] data_a;
    logic [2:0] sel_a;
    logic       mode_a;
    logic       start_a;
    logic [7:0] dwell_a;
    logic [0:0] dout_a;
    logic [2:0] chan_a;
    logic       valid_a;
    logic       done_a;
    logic       state_a;

    muxn_scan #(.N(8), .W(1), .DWELL_W(8)) dut_a (
        .CLK      (clk),
        .RESET    (rst),
        .DATA_IN  (data_a),
        .SELECT   (sel_a),
        .MODE     (mode_a),
        .START    (start_a),
        .DWELL    (dwell_a),
        .DATA_OUT (dout_a),
        .CHANNEL  (chan_a),
        .VALID    (valid_a),
        .DONE     (done_a),
        .STATE    (state_a)
    );

    // ---------------- instance B: N=4, W=4 ----------------
    logic [15:0] data_b;
    logic [1:0]  sel_b;
    logic        mode_b;
    logic        start_b;
    logic [7:0]  dwell_b;
    logic [3:0]  dout_b;
    logic [1:0]  chan_b;
    logic        valid_b;
    logic        done_b;
    logic        state_b;

    muxn_scan #(.N(4), .W(4), .DWELL_W(8)) dut_b (
        .CLK      (clk),
        .RESET    (rst),
        .DATA_IN  (data_b),
        .SELECT   (sel_b),
        .MODE     (mode_b),
        .START    (start_b),
        .DWELL    (dwell_b),
        .DATA_OUT (dout_b),
        .CHANNEL  (chan_b),
        .VALID    (valid_b),
        .DONE     (done_b),
        .STATE    (state_b)
    );

    int checks;
    int errors;

    // Advance one clock and settle just past the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (dout_a !== 1'b0)  begin errors++; $display("FAIL reset_dout_a: got %b want 0", dout_a); end
        checks++; if (chan_a !== 3'd0)  begin errors++; $display("FAIL reset_chan_a: got %0d want 0", chan_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL reset_valid_a: got %b want 0", valid_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL reset_done_a: got %b want 0", done_a); end
        checks++; if (dout_b !== 4'h0)  begin errors++; $display("FAIL reset_dout_b: got %h want 0", dout_b); end
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL reset_valid_b: got %b want 0", valid_b); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_manual();
        logic [7:0] pattern;
        pattern = 8'b10101010;
        data_a  = pattern;
        mode_a  = 1'b0;
        start_a = 1'b1;   // ignored in manual mode
        for (int s = 0; s < 8; s++) begin
            sel_a = 3'(s);
            for (int k = 0; k < 10; k++) begin
                tick();
                checks++; if (dout_a !== pattern[s]) begin errors++; $display("FAIL manual_data sel=%0d: got %b want %b", s, dout_a, pattern[s]); end
                checks++; if (chan_a !== 3'(s))      begin errors++; $display("FAIL manual_chan: got %0d want %0d", chan_a, s); end
                checks++; if (valid_a !== 1'b1)      begin errors++; $display("FAIL manual_valid: got %b want 1", valid_a); end
                checks++; if (done_a !== 1'b0)       begin errors++; $display("FAIL manual_done: got %b want 0", done_a); end
            end
        end
        start_a = 1'b0;
    endtask

    task automatic test_manual_random();
        logic [7:0]  ed_a;
        logic [2:0]  es_a;
        logic [15:0] ed_b;
        logic [1:0]  es_b;
        logic [3:0]  want_b;
        mode_a = 1'b0;
        mode_b = 1'b0;
        for (int i = 0; i < 40; i++) begin
            data_a = 8'($urandom);
            sel_a  = 3'($urandom_range(0, 7));
            data_b = 16'($urandom);
            sel_b  = 2'($urandom_range(0, 3));
            ed_a = data_a; es_a = sel_a;
            ed_b = data_b; es_b = sel_b;
            tick();
            want_b = 4'((ed_b >> (4 * es_b)) & 16'hF);
            checks++; if (dout_a !== ed_a[es_a]) begin errors++; $display("FAIL rand_manual_data_a: got %b want %b", dout_a, ed_a[es_a]); end
            checks++; if (chan_a !== es_a)       begin errors++; $display("FAIL rand_manual_chan_a: got %0d want %0d", chan_a, es_a); end
            checks++; if (dout_b !== want_b)     begin errors++; $display("FAIL rand_manual_data_b: got %h want %h", dout_b, want_b); end
            checks++; if (chan_b !== es_b)       begin errors++; $display("FAIL rand_manual_chan_b: got %0d want %0d", chan_b, es_b); end
            checks++; if (valid_b !== 1'b1)      begin errors++; $display("FAIL rand_manual_valid_b: got %b want 1", valid_b); end
        end
    endtask

    // One sweep on instance A checked against the sweep-order model.
    task automatic run_sweep_a(input int dwell, input int new_dwell, input int change_at,
                               input int pulse_at, input bit hold_start, input bit live,
                               input logic [7:0] data, input string tag);
        logic [3:0] exp_q[$];
        logic [3:0] exp;
        logic [7:0] edge_data;
        int total;
        total = 8 * (dwell + 1);
        for (int c = 0; c < 8; c++)
            for (int k = 0; k <= dwell; k++)
                exp_q.push_back({(c == 7 && k == dwell), 3'(c)});
        data_a  = data;
        mode_a  = 1'b1;
        dwell_a = 8'(dwell);
        start_a = 1'b1;
        tick();
        checks++; if (valid_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL %s_start_gap: got valid=%b done=%b want 0 0", tag, valid_a, done_a); end
        start_a = hold_start;
        for (int n = 1; n <= total; n++) begin
            edge_data = data_a;
            tick();
            exp = exp_q.pop_front();
            checks++; if (valid_a !== 1'b1)         begin errors++; $display("FAIL %s_valid n=%0d: got %b want 1", tag, n, valid_a); end
            checks++; if (chan_a !== exp[2:0])      begin errors++; $display("FAIL %s_chan n=%0d: got %0d want %0d", tag, n, chan_a, exp[2:0]); end
            checks++; if (dout_a !== edge_data[exp[2:0]]) begin errors++; $display("FAIL %s_data n=%0d: got %b want %b", tag, n, dout_a, edge_data[exp[2:0]]); end
            checks++; if (done_a !== exp[3])        begin errors++; $display("FAIL %s_done n=%0d: got %b want %b", tag, n, done_a, exp[3]); end
            if (n == change_at) dwell_a = 8'(new_dwell);
            start_a = hold_start || (n == pulse_at);
            if (live) data_a = 8'($urandom);
        end
        if (!hold_start) begin
            tick();
            checks++; if (valid_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL %s_after: got valid=%b done=%b want 0 0", tag, valid_a, done_a); end
        end
    endtask

    task automatic test_scan_dwell0();
        run_sweep_a(0, 0, 0, 0, 1'b0, 1'b0, 8'b10101010, "scan_d0");
    endtask

    task automatic test_scan_dwell_change();
        run_sweep_a(2, 5, 4, 0, 1'b0, 1'b0, 8'b10101010, "scan_d2_chg");
    endtask

    task automatic test_start_during_scan();
        run_sweep_a(1, 1, 0, 5, 1'b0, 1'b0, 8'($urandom), "scan_restart");
    endtask

    task automatic test_back_to_back();
        run_sweep_a(1, 1, 0, 0, 1'b1, 1'b0, 8'($urandom), "b2b_first");
        run_sweep_a(0, 0, 0, 0, 1'b0, 1'b0, 8'($urandom), "b2b_second");
    endtask

    task automatic test_scan_random();
        for (int r = 0; r < 6; r++)
            run_sweep_a($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(1, 8),
                        0, 1'b0, 1'b1, 8'($urandom), "scan_rand");
    endtask

    task automatic test_abort();
        logic [7:0] edge_data;
        logic [2:0] edge_sel;
        bit found;
        bit done_seen;
        data_a  = 8'($urandom);
        dwell_a = 8'd1;
        mode_a  = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (valid_a === 1'b1 && chan_a === 3'd3) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL abort_reach_ch3: got no channel 3 sample want one within 40 cycles"); end
        sel_a  = 3'($urandom_range(0, 7));
        data_a = 8'($urandom);
        edge_data = data_a;
        edge_sel  = sel_a;
        mode_a = 1'b0;
        tick();
        checks++; if (dout_a !== edge_data[edge_sel]) begin errors++; $display("FAIL abort_data: got %b want %b", dout_a, edge_data[edge_sel]); end
        checks++; if (chan_a !== edge_sel) begin errors++; $display("FAIL abort_chan: got %0d want %0d", chan_a, edge_sel); end
        checks++; if (valid_a !== 1'b1)    begin errors++; $display("FAIL abort_valid: got %b want 1", valid_a); end
        checks++; if (done_a !== 1'b0)     begin errors++; $display("FAIL abort_done: got %b want 0", done_a); end
        done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            start_a = 1'($urandom_range(0, 1));
            tick();
            if (done_a !== 1'b0) done_seen = 1'b1;
        end
        start_a = 1'b0;
        checks++; if (done_seen) begin errors++; $display("FAIL abort_no_done: got DONE pulse want none"); end
    endtask

    task automatic test_reset_mid_sweep();
        bit found;
        data_a  = 8'($urandom);
        dwell_a = 8'd2;
        mode_a  = 1'b1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (valid_a === 1'b1 && chan_a === 3'd5) found = 1'b1;
        end
        checks++; if (!found) begin errors++; $display("FAIL rstmid_reach_ch5: got no channel 5 sample want one within 40 cycles"); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (dout_a !== 1'b0)  begin errors++; $display("FAIL rstmid_dout: got %b want 0", dout_a); end
        checks++; if (chan_a !== 3'd0)  begin errors++; $display("FAIL rstmid_chan: got %0d want 0", chan_a); end
        checks++; if (valid_a !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", valid_a); end
        checks++; if (done_a !== 1'b0)  begin errors++; $display("FAIL rstmid_done: got %b want 0", done_a); end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (valid_a !== 1'b0 || done_a !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got valid=%b done=%b want 0 0", valid_a, done_a); end
            checks++; if (dout_a !== 1'b0 || chan_a !== 3'd0)  begin errors++; $display("FAIL rstmid_hold: got dout=%b chan=%0d want 0 0", dout_a, chan_a); end
        end
    endtask

    task automatic test_wide();
        logic [3:0] exp_d [8];
        exp_d = '{4'h5, 4'h5, 4'hA, 4'hA, 4'h3, 4'h3, 4'hC, 4'hC};
        data_b  = 16'hC3A5;
        dwell_b = 8'd1;
        mode_b  = 1'b1;
        start_b = 1'b1;
        tick();
        checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL wide_start_gap: got %b want 0", valid_b); end
        start_b = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            checks++; if (valid_b !== 1'b1)      begin errors++; $display("FAIL wide_valid n=%0d: got %b want 1", n, valid_b); end
            checks++; if (dout_b !== exp_d[n])   begin errors++; $display("FAIL wide_data n=%0d: got %h want %h", n, dout_b, exp_d[n]); end
            checks++; if (chan_b !== 2'(n / 2))  begin errors++; $display("FAIL wide_chan n=%0d: got %0d want %0d", n, chan_b, n / 2); end
            checks++; if (done_b !== (n == 7))   begin errors++; $display("FAIL wide_done n=%0d: got %b want %b", n, done_b, (n == 7)); end
        end
        tick();
        checks++; if (valid_b !== 1'b0 || done_b !== 1'b0) begin errors++; $display("FAIL wide_after: got valid=%b done=%b want 0 0", valid_b, done_b); end
    endtask

    task automatic test_wide_random();
        logic [2:0]  exp_q[$];
        logic [2:0]  exp;
        logic [15:0] edge_data;
        logic [3:0]  want;
        int dwell;
        for (int r = 0; r < 4; r++) begin
            dwell = $urandom_range(0, 4);
            for (int c = 0; c < 4; c++)
                for (int k = 0; k <= dwell; k++)
                    exp_q.push_back({(c == 3 && k == dwell), 2'(c)});
            data_b  = 16'($urandom);
            dwell_b = 8'(dwell);
            mode_b  = 1'b1;
            start_b = 1'b1;
            tick();
            start_b = 1'b0;
            for (int n = 0; n < 4 * (dwell + 1); n++) begin
                edge_data = data_b;
                dwell_b = 8'($urandom);
                tick();
                exp  = exp_q.pop_front();
                want = 4'((edge_data >> (4 * exp[1:0])) & 16'hF);
                checks++; if (valid_b !== 1'b1)    begin errors++; $display("FAIL wide_rand_valid: got %b want 1", valid_b); end
                checks++; if (chan_b !== exp[1:0]) begin errors++; $display("FAIL wide_rand_chan: got %0d want %0d", chan_b, exp[1:0]); end
                checks++; if (dout_b !== want)     begin errors++; $display("FAIL wide_rand_data: got %h want %h", dout_b, want); end
                checks++; if (done_b !== exp[2])   begin errors++; $display("FAIL wide_rand_done: got %b want %b", done_b, exp[2]); end
                data_b = 16'($urandom);
            end
            tick();
            checks++; if (valid_b !== 1'b0) begin errors++; $display("FAIL wide_rand_after: got %b want 0", valid_b); end
        end
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b0;
        data_a  = '0; sel_a = '0; mode_a = 1'b0; start_a = 1'b0; dwell_a = '0;
        data_b  = '0; sel_b = '0; mode_b = 1'b0; start_b = 1'b0; dwell_b = '0;
        #2;
        test_reset();
        test_manual();
        test_manual_random();
        test_scan_dwell0();
        test_scan_dwell_change();
        test_start_during_scan();
        test_back_to_back();
        test_scan_random();
        test_abort();
        test_reset_mid_sweep();
        test_wide();
        test_wide_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muxn_scan.md
# muxn_scan

Parametrised N-channel, W-bit multiplexer with a registered output and a built-in channel sequencer. In manual mode it behaves as a registered N-to-1 mux driven by `SELECT`. In scan mode it sweeps channels 0..N-1 once, holding each for a programmable dwell time, flagging each sample with `VALID` and the sweep end with `DONE`. It sits between a bank of W-bit sources and a single-lane consumer such as a serialiser, logger or test-bench probe.

## Interface
- `N`, 8: channel count; power of two, ≥2.
- `W`, 1: data width per channel, ≥1.
- `DWELL_W`, 8: width of the `DWELL` input.
- `SEL_W`, clog2(N): derived localparam, not overridable.

- `CLK` in 1: single clock, rising edge.
- `RESET` in 1: asynchronous, active-high.
- `DATA_IN` in N*W: channel i occupies `DATA_IN[i*W +: W]`.
- `SELECT` in SEL_W: channel index used in manual mode.
- `MODE` in 1: 0 = manual, 1 = scan.
- `START` in 1: sampled high in IDLE with MODE=1, begins one sweep.
- `DWELL` in DWELL_W: cycles per channel minus 1; sampled at start.
- `DATA_OUT` out W: registered selected data.
- `CHANNEL` out SEL_W: index of the channel currently shown on `DATA_OUT`.
- `VALID` out 1: `DATA_OUT`/`CHANNEL` hold a sample this cycle.
- `DONE` out 1: one-cycle pulse on the final sample of a sweep.

## Operation
- State machine has two states:
  - IDLE: manual mode, or waiting in scan mode.
  - SCAN: sweep in progress.
- Internal registers: channel counter `ch` (SEL_W bits), dwell counter `cnt` (DWELL_W bits), latched dwell `dw`.
- IDLE, MODE=0, each edge:
  - `DATA_OUT` <= slice[`SELECT`]
  - `CHANNEL` <= `SELECT`
  - `VALID` <= 1
  - `DONE` <= 0
  - `START` is ignored.
- IDLE, MODE=1, `START`=0: `VALID` <= 0; `DATA_OUT` and `CHANNEL` hold.
- IDLE, MODE=1, `START`=1:
  - next state SCAN
  - `ch` <= 0
  - `cnt` <= `DWELL`
  - `dw` <= `DWELL`
  - `VALID` <= 0 this edge.
- SCAN, each edge:
  - `DATA_OUT` <= slice[`ch`]
  - `CHANNEL` <= `ch`
  - `VALID` <= 1
- SCAN, counter update on each edge:
  - If `cnt`≠0: `cnt` <= `cnt`-1.
  - If `cnt`=0 and `ch`≠N-1: `ch` <= `ch`+1 and `cnt` <= `dw`.
  - If `cnt`=0 and `ch`=N-1: `DONE` <= 1 and next state IDLE.
- Sweep length is exactly N*(`DWELL`+1) `VALID` cycles.
- `DWELL` changes during SCAN have no effect because `dw` is latched at start.
- `START` during SCAN is ignored; no restart.
- MODE dropping to 0 during SCAN aborts the sweep:
  - On the next edge the block returns to IDLE and performs the manual load on that same edge.
  - No `DONE` pulse is issued.
- MODE=1 with `START` held high after `DONE`: a new sweep starts on the first IDLE edge, giving back-to-back sweeps with one `VALID`=0 cycle between them.
- `DATA_IN` is sampled live every cycle; the block does no input buffering.

## Timing
- Reset: asynchronous assertion forces all of the following, with no clock required:
  - state IDLE
  - `ch`=0, `cnt`=0, `dw`=0
  - `DATA_OUT`=0, `CHANNEL`=0, `VALID`=0, `DONE`=0
- Deassertion: the block is active from the first rising edge after `RESET` falls.
- Reset mid-sweep: the sweep is abandoned and no `DONE` is issued.
- Manual latency: one cycle from `SELECT`/`DATA_IN` to `DATA_OUT`.
- Scan latency: `START` sampled at edge t0; first sample (channel 0) appears after edge t1.
- `DONE` is asserted in the same cycle as the last `VALID` sample of channel N-1. Both drop after the following edge, unless manual mode re-asserts `VALID`.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Manual, N=8, W=1, `DATA_IN`=8'b10101010, `SELECT` stepped 0..7 every 10 cycles:
  - `DATA_OUT` = 0,1,0,1,0,1,0,1, each one cycle after the `SELECT` change.
  - `VALID`=1 throughout; `CHANNEL` tracks `SELECT`.
- Scan, `DWELL`=0, same data, one-cycle `START`:
  - 8 consecutive `VALID` cycles with `CHANNEL` 0..7 and `DATA_OUT` 0,1,0,1,0,1,0,1.
  - `DONE` high only on the 8th; `VALID`=0 afterwards.
- Scan, `DWELL`=2, with `DWELL` changed to 5 mid-sweep:
  - 24 `VALID` cycles, each channel shown for exactly 3 cycles.
  - `DONE` on cycle 24.
- Abort and restart:
  - MODE→0 during channel 3: next cycle shows manual `SELECT` data, no `DONE`.
  - `START` pulse during SCAN: no restart.
- Reset mid-sweep: `RESET` asserted between edges during channel 5 → all outputs 0 immediately. After release with MODE=1 and no `START`, `VALID` stays 0.
- Parameters N=4, W=4, `DATA_IN`=16'hC3A5, scan with `DWELL`=1:
  - `DATA_OUT` = 5,5,A,A,3,3,C,C.
  - `CHANNEL` = 0,0,1,1,2,2,3,3.
  - `DONE` on the 8th cycle.
